// File: rtl/ex_muldiv_ctrl.sv
// Iterative RV32M mul/div sequencer with shift-add multiplier and restoring divider.
// 33-cycle start-to-done (1 cycle for div-by-zero/overflow); holds EX via stall_ex; flush aborts.
module ex_muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        stall_ex,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [2:0]  op;
  logic [4:0]  cnt;
  logic        sa;
  logic        sb;
  logic [31:0] mag_b;
  logic [63:0] prod;
  logic [31:0] rem;

  logic        sgn_a;
  logic        sgn_b;
  logic        in_sa;
  logic        in_sb;
  logic [31:0] in_ma;
  logic [31:0] in_mb;
  logic        is_div;
  logic        div0;
  logic        ovf;
  logic [31:0] bypass_res;

  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin sgn_a = 1'b1; sgn_b = 1'b1; end
      3'b010:                         sgn_a = 1'b1;
      default:                        ;
    endcase
  end

  assign in_sa  = sgn_a & a[31];
  assign in_sb  = sgn_b & b[31];
  assign in_ma  = in_sa ? (~a + 32'd1) : a;
  assign in_mb  = in_sb ? (~b + 32'd1) : b;
  assign is_div = funct3[2];
  assign div0   = is_div && (b == 32'd0);
  assign ovf    = is_div && !funct3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  always_comb begin
    bypass_res = 32'd0;
    if (div0)
      bypass_res = funct3[1] ? a : 32'hFFFF_FFFF;
    else if (ovf)
      bypass_res = funct3[1] ? 32'd0 : 32'h8000_0000;
  end

  // Multiply: prod[31:0] holds the shifting multiplier, prod[63:32] the accumulating high half.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  assign mul_sum  = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mag_b} : 33'd0);
  assign mul_next = {mul_sum, prod[31:1]};

  // Divide: prod[31:0] doubles as the dividend/quotient shift register.
  logic [32:0] rem_sh;
  logic [32:0] rem_diff;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  assign rem_sh   = {rem, prod[31]};
  assign rem_diff = rem_sh - {1'b0, mag_b};
  assign rem_next = rem_diff[32] ? rem_sh[31:0] : rem_diff[31:0];
  assign quo_next = {prod[30:0], ~rem_diff[32]};

  logic [63:0] prod_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] fin_res;
  assign prod_s = (sa ^ sb) ? (~mul_next + 64'd1) : mul_next;
  assign quo_s  = (sa ^ sb) ? (~quo_next + 32'd1) : quo_next;
  assign rem_s  = sa ? (~rem_next + 32'd1) : rem_next;

  always_comb begin
    case (op)
      3'b000:                 fin_res = prod_s[31:0];
      3'b001, 3'b010, 3'b011: fin_res = prod_s[63:32];
      3'b100, 3'b101:         fin_res = quo_s;
      default:                fin_res = rem_s;
    endcase
  end

  assign stall_ex = !flush && (((state == IDLE) && start) || (state == BUSY));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      done   <= 1'b0;
      result <= 32'd0;
      cnt    <= 5'd0;
      op     <= 3'd0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      mag_b  <= 32'd0;
      prod   <= 64'd0;
      rem    <= 32'd0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (start) begin
            op    <= funct3;
            sa    <= in_sa;
            sb    <= in_sb;
            mag_b <= in_mb;
            prod  <= {32'd0, in_ma};
            rem   <= 32'd0;
            cnt   <= 5'd0;
            if (div0 || ovf) begin
              result <= bypass_res;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              state <= BUSY;
            end
          end
          BUSY: begin
            cnt <= cnt + 5'd1;
            if (op[2]) begin
              rem        <= rem_next;
              prod[31:0] <= quo_next;
            end else begin
              prod <= mul_next;
            end
            if (cnt == 5'd31) begin
              result <= fin_res;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/ex_muldiv_ctrl.md
# ex_muldiv_ctrl

Sequencer for the shared iterative RV32M multiply/divide resource attached to the EX stage. It holds the EX stage with `stall_ex` while a MUL/DIV/REM instruction iterates, and returns a one-cycle `done` with the 32-bit result. It aborts cleanly on a pipeline flush from a mispredicted older instruction. It contains its own shift-add multiplier and restoring divider datapath plus the control FSM.

## Interface
Parameters: none (XLEN fixed at 32, iteration count fixed at 32).

- `clk`  in  1  pipeline clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-low reset; `rst==0` at a rising edge resets the block
- `start`  in  1  EX holds a valid RV32M instruction (op_reg, funct7=0000001); held high until `done`
- `funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `a`  in  32  rs1 operand (forwarded value)
- `b`  in  32  rs2 operand (forwarded value)
- `flush`  in  1  kill any in-progress operation (EX instruction squashed)
- `stall_ex`  out  1  hold IF/ID/EX; combinational
- `done`  out  1  registered one-cycle pulse; `result` valid
- `result`  out  32  registered result; holds its value until the next `done`

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if `start && !flush`, capture `funct3`, the operand magnitudes, and the sign flags. Load `cnt=0`. Go to BUSY.
  - Divide by zero bypasses BUSY and goes to DONE.
  - Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF) also bypasses BUSY and goes to DONE.
- Sign rules:
  - MULH and DIV/REM: a and b are signed.
  - MULHSU: a is signed, b is unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - MUL: low word, with sign handling identical to MULH.
- BUSY, multiply: one shift-add step per cycle on a 64-bit accumulator.
- BUSY, divide: one restoring step per cycle (33-bit partial remainder).
- BUSY: `cnt` increments each cycle. At `cnt==31` go to DONE.
- Entering DONE, `result` is loaded with:
  - MUL: product[31:0]. MULH*: product[63:32].
  - Product is negated (two's complement, 64-bit) when the effective sign is negative.
  - Quotient sign = sa^sb. Remainder sign = sa.
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = a (unmodified).
  - Overflow: quotient = 0x80000000, remainder = 0.
- DONE: `done=1` for one cycle. Unconditionally go to IDLE. `start` is ignored in DONE.
- `stall_ex = !flush && ((IDLE && start) || BUSY)`. It is 0 in DONE, which lets EX advance with the result.
- Flush: from any state, next state is IDLE.
  - No `done` is produced for the killed operation. `result` is not updated.
  - If `flush` is high in DONE, `done` still pulses that cycle. The consumer gates the pulse with its own valid.
- Reset values: state IDLE, `done=0`, `result=0`, `cnt=0`, `stall_ex=0` (given `start=0`).
- Reset mid-operation discards all state. The first `start` after reset is accepted in IDLE normally.

## Timing
- Normal op: `start` seen in cycle 0 (IDLE). BUSY spans cycles 1..32. DONE is cycle 33.
- `stall_ex` is high in cycles 0..32. `done` and the `result` update are visible in cycle 33.
- Total latency: 33 cycles from `start` to `done`.
- Bypass (div0/overflow): `start` in cycle 0, `done` in cycle 1; `stall_ex` is high only in cycle 0.
- Back-to-back: a second M instruction can present `start` in cycle 34 (the IDLE cycle after DONE). It is accepted immediately.
- Operands `a`/`b` are sampled only in the IDLE accept cycle. Later changes during BUSY have no effect.
- `flush` in cycle k (BUSY) makes the block IDLE in cycle k+1. `stall_ex` is 0 in cycle k. A new `start` is accepted in cycle k+1.

## Test plan
- MUL a=7, b=0xFFFFFFFD (-3) -> `stall_ex` high cycles 0..32, `done` at cycle 33, `result`=0xFFFFFFEB. MULH of the same operands -> 0xFFFFFFFF.
- MULH a=b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM of the same operands -> 0xFFFFFFFF. DIVU a=100, b=7 -> 14. REMU of the same operands -> 2.
- DIVU a=5, b=0 -> `done` at cycle 1, `result`=0xFFFFFFFF. REM a=5, b=0 -> 5. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 at cycle 1. REM of the same operands -> 0.
- Start DIV, assert `flush` at cycle 10:
  - `stall_ex`=0 at cycle 10 and no `done` follows.
  - A new MUL 3*4 with `start` at cycle 11 gives `done` at cycle 44, `result`=12.
- Drive `rst=0` at cycle 15 of a MUL -> next cycle IDLE, `done=0`, `result=0`. Back-to-back MUL then DIVU gives `done` at cycles 33 and 67.
